// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// FSM encoding, SPI mode codes and the default word width.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and user-side bundle of the SPI responder.
// SPI_SLAVE_STATUS_EN adds rx ack and overrun/underrun pulses.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  i_sclk;
    logic                  i_cs_n;
    logic                  i_mosi;
    logic                  o_miso;
    logic                  o_miso_en;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_busy;

`ifdef SPI_SLAVE_STATUS_EN
    logic                  i_rx_ack;
    logic                  o_overrun;
    logic                  o_underrun;

    modport slave (
        input  i_sclk, i_cs_n, i_mosi,
        input  i_tx_data, i_tx_valid, i_rx_ack,
        output o_miso, o_miso_en, o_tx_ready,
        output o_rx_data, o_rx_valid, o_busy,
        output o_overrun, o_underrun
    );

    modport master (
        output i_sclk, i_cs_n, i_mosi,
        output i_tx_data, i_tx_valid, i_rx_ack,
        input  o_miso, o_miso_en, o_tx_ready,
        input  o_rx_data, o_rx_valid, o_busy,
        input  o_overrun, o_underrun
    );
`else
    modport slave (
        input  i_sclk, i_cs_n, i_mosi,
        input  i_tx_data, i_tx_valid,
        output o_miso, o_miso_en, o_tx_ready,
        output o_rx_data, o_rx_valid, o_busy
    );

    modport master (
        output i_sclk, i_cs_n, i_mosi,
        output i_tx_data, i_tx_valid,
        input  o_miso, o_miso_en, o_tx_ready,
        input  o_rx_data, o_rx_valid, o_busy
    );
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronises SCLK/CS_n/MOSI and derives one-cycle edge strobes.
// Strobes and the MOSI/CS copies share one pipeline depth.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic lead,
    output logic trail,
    output logic cs_n_s,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_sy;
    logic                   cs_sy;
    logic                   mosi_sy;
    logic                   sclk_q;
    logic                   cs_q;
    logic                   mosi_q;

    assign sclk_sy = sclk_ff[SYNC_STAGES-1];
    assign cs_sy   = cs_ff[SYNC_STAGES-1];
    assign mosi_sy = mosi_ff[SYNC_STAGES-1];

    // Metastability chains; reset to the idle pin levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff <= {SYNC_STAGES{CPOL}};
            cs_ff   <= '1;
            mosi_ff <= '0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs_n};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
        end
    end

    // Edge detect; leading edge leaves the CPOL idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= CPOL;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            lead    <= 1'b0;
            trail   <= 1'b0;
            cs_fall <= 1'b0;
            cs_rise <= 1'b0;
        end else begin
            sclk_q  <= sclk_sy;
            cs_q    <= cs_sy;
            mosi_q  <= mosi_sy;
            lead    <= (sclk_sy != sclk_q) && (sclk_sy != CPOL);
            trail   <= (sclk_sy != sclk_q) && (sclk_sy == CPOL);
            cs_fall <= cs_q & ~cs_sy;
            cs_rise <= ~cs_q & cs_sy;
        end
    end

    assign cs_n_s = cs_q;
    assign mosi_s = mosi_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: full duplex, MSB first, oversampled pins.
// Optional SPI_SLAVE_STATUS_EN adds overrun/underrun pulses.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic        i_clk,
    input logic        i_reset,
    spi_slave_if.slave bus
);

    localparam int         CW   = $clog2(DATA_WIDTH);
    localparam logic [1:0] MODE = {CPOL, CPHA};
    localparam bit         PH1  = (MODE == MODE1) || (MODE == MODE3);

    state_t                state_q;
    state_t                state_d;
    logic                  lead;
    logic                  trail;
    logic                  cs_n_s;
    logic                  cs_fall;
    logic                  cs_rise;
    logic                  mosi_s;
    logic                  sample_stb;
    logic                  shift_stb;
    logic                  do_load;
    logic                  do_shift;
    logic                  do_sample;
    logic                  clr_fresh;
    logic                  word_done;
    logic                  busy;
    logic                  tx_write;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic [CW-1:0]         bit_cnt;
    logic                  reload_q;
    logic                  fresh_q;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL)
    ) u_sync (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .sclk    (bus.i_sclk),
        .cs_n    (bus.i_cs_n),
        .mosi    (bus.i_mosi),
        .lead    (lead),
        .trail   (trail),
        .cs_n_s  (cs_n_s),
        .cs_fall (cs_fall),
        .cs_rise (cs_rise),
        .mosi_s  (mosi_s)
    );

    assign busy      = (state_q != ST_IDLE);
    assign tx_write  = bus.i_tx_valid & ~hold_full;
    assign rx_next   = {rx_sr[DATA_WIDTH-2:0], mosi_s};
    assign word_done = do_sample && (bit_cnt == CW'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        clr_fresh  = 1'b0;
        sample_stb = (PH1 ? trail : lead) & ~cs_n_s;
        shift_stb  = (PH1 ? lead : trail) & ~cs_n_s;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                do_load = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                do_sample = sample_stb;
                if (shift_stb) begin
                    if (reload_q) begin
                        do_load = 1'b1;
                    end else if (fresh_q) begin
                        clr_fresh = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            state_d   = ST_IDLE;
            do_load   = 1'b0;
            do_shift  = 1'b0;
            do_sample = 1'b0;
            clr_fresh = 1'b0;
        end
    end

    // Shift registers, bit counter and received word
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt    <= '0;
            reload_q   <= 1'b0;
            fresh_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (do_load) begin
                tx_sr    <= hold_full ? hold_q : '0;
                reload_q <= 1'b0;
                fresh_q  <= PH1 && (state_q == ST_LOAD);
            end else if (do_shift) begin
                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end else if (clr_fresh) begin
                fresh_q <= 1'b0;
            end
            if (state_q == ST_LOAD) begin
                bit_cnt <= '0;
            end
            if (do_sample) begin
                rx_sr <= rx_next;
                if (word_done) begin
                    bit_cnt    <= '0;
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                    reload_q   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // Holding register; a load empties it before a same-cycle write
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (tx_write) begin
                hold_q    <= bus.i_tx_data;
                hold_full <= 1'b1;
            end else if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign bus.o_miso     = busy & tx_sr[DATA_WIDTH-1];
    assign bus.o_miso_en  = busy;
    assign bus.o_busy     = busy;
    assign bus.o_tx_ready = ~hold_full;
    assign bus.o_rx_data  = rx_data_q;
    assign bus.o_rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_STATUS_EN
    logic pend_q;
    logic overrun_q;
    logic underrun_q;

    // Unacknowledged-word tracking and status pulses
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pend_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (rx_valid_q) begin
                pend_q <= ~bus.i_rx_ack;
            end else if (bus.i_rx_ack) begin
                pend_q <= 1'b0;
            end
            overrun_q  <= word_done & pend_q & ~bus.i_rx_ack;
            underrun_q <= do_load & ~hold_full;
        end
    end

    assign bus.o_overrun  = overrun_q;
    assign bus.o_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 and a mode-3 instance
// driven by a behavioural SPI master.
module tb_spi_slave;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ph    = 2'b00;
    logic [1:0] csn   = 2'b11;
    logic       mosi_v = 1'b0;
    logic [7:0] txd [2];
    logic [1:0] txv   = 2'b00;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] q0 [$];
    logic [7:0] q3 [$];

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(8)) if0 ();
    spi_slave_if #(.DATA_WIDTH(8)) if3 ();

    assign if0.i_sclk     = ph[0];
    assign if3.i_sclk     = ~ph[1];
    assign if0.i_cs_n     = csn[0];
    assign if3.i_cs_n     = csn[1];
    assign if0.i_mosi     = mosi_v;
    assign if3.i_mosi     = mosi_v;
    assign if0.i_tx_data  = txd[0];
    assign if3.i_tx_data  = txd[1];
    assign if0.i_tx_valid = txv[0];
    assign if3.i_tx_valid = txv[1];
`ifdef SPI_SLAVE_STATUS_EN
    assign if0.i_rx_ack   = 1'b1;
    assign if3.i_rx_ack   = 1'b1;
`endif

    spi_slave #(
        .DATA_WIDTH (8),
        .CPOL       (1'b0),
        .CPHA       (1'b0),
        .SYNC_STAGES(2)
    ) u_m0 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if0)
    );

    spi_slave #(
        .DATA_WIDTH (8),
        .CPOL       (1'b1),
        .CPHA       (1'b1),
        .SYNC_STAGES(3)
    ) u_m3 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if3)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen/timed out where none expected", name);
    endtask

    function automatic logic rdy(input int m);
        return (m == 0) ? if0.o_tx_ready : if3.o_tx_ready;
    endfunction

    function automatic logic miso(input int m);
        return (m == 0) ? if0.o_miso : if3.o_miso;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_tx(input int m, input logic [7:0] d);
        int k = 0;
        while (!rdy(m) && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (k >= 64) fail_now("tx_ready_timeout");
        txd[m] = d;
        txv[m] = 1'b1;
        @(negedge clk);
        txv[m] = 1'b0;
    endtask

    // Master samples MISO at the end of each bit window
    task automatic xfer(input int m, input int n, input logic [7:0] dout,
                        input int half, output logic [7:0] din);
        din = '0;
        for (int i = 0; i < n; i++) begin
            if (m == 0) begin
                mosi_v = dout[7-i];
                wait_cyc(half);
                ph[0] = 1'b1;
                wait_cyc(half);
                din[7-i] = miso(m);
                ph[0] = 1'b0;
            end else begin
                ph[1] = 1'b1;
                mosi_v = dout[7-i];
                wait_cyc(half);
                ph[1] = 1'b0;
                wait_cyc(half);
                din[7-i] = miso(m);
            end
        end
    endtask

    task automatic do_word(input int m, input bit load, input logic [7:0] tx,
                           input logic [7:0] rx, input int half);
        logic [7:0] din;
        if (load) put_tx(m, tx);
        if (m == 0) q0.push_back(rx);
        else q3.push_back(rx);
        csn[m] = 1'b0;
        wait_cyc(8);
        xfer(m, 8, rx, half, din);
        check((m == 0) ? "miso0" : "miso3", din, load ? tx : 8'h00);
        wait_cyc(half);
        csn[m] = 1'b1;
        wait_cyc(8);
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the queue head
    always @(negedge clk) begin
        if (rst_n && if0.o_rx_valid) begin
            if (q0.size() == 0) fail_now("rx0_unexpected");
            else check("rx0", if0.o_rx_data, q0.pop_front());
        end
        if (rst_n && if3.o_rx_valid) begin
            if (q3.size() == 0) fail_now("rx3_unexpected");
            else check("rx3", if3.o_rx_data, q3.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d1;
        logic [7:0] d2;
        int halves [4];
        halves = '{3, 4, 8, 16};
        txd[0] = '0;
        txd[1] = '0;
        wait_cyc(3);
        check("rst_ready0", if0.o_tx_ready, 1);
        check("rst_busy0", if0.o_busy, 0);
        check("rst_miso_en0", if0.o_miso_en, 0);
        check("rst_rx0", if0.o_rx_data, 0);
        check("rst_ready3", if3.o_tx_ready, 1);
        check("rst_miso3", if3.o_miso, 0);
        rst_n = 1'b1;
        wait_cyc(4);

        // Mode 0: tx A5, rx 3C
        put_tx(0, 8'hA5);
        check("tx_ready_full", rdy(0), 0);
        q0.push_back(8'h3C);
        csn[0] = 1'b0;
        wait_cyc(8);
        check("tx_ready_load", rdy(0), 1);
        check("busy_on", if0.o_busy, 1);
        check("miso_en_on", if0.o_miso_en, 1);
        xfer(0, 8, 8'h3C, 4, d1);
        check("miso_a5", d1, 8'hA5);
        wait_cyc(4);
        csn[0] = 1'b1;
        wait_cyc(8);
        check("busy_off", if0.o_busy, 0);
        check("miso_en_off", if0.o_miso_en, 0);
        check("rx_data_3c", if0.o_rx_data, 8'h3C);

        // Mode 3: back-to-back words under one CS
        put_tx(1, 8'h81);
        q3.push_back(8'h12);
        q3.push_back(8'h34);
        csn[1] = 1'b0;
        wait_cyc(8);
        put_tx(1, 8'h7E);
        xfer(1, 8, 8'h12, 4, d1);
        xfer(1, 8, 8'h34, 4, d2);
        check("b2b_miso_81", d1, 8'h81);
        check("b2b_miso_7e", d2, 8'h7E);
        wait_cyc(4);
        csn[1] = 1'b1;
        wait_cyc(8);
        check("b2b_ready", rdy(1), 1);
        check("b2b_rx_last", if3.o_rx_data, 8'h34);

        // Empty holding register: zeros on MISO
        do_word(0, 1'b0, 8'h00, 8'hFF, 8);

        // CS released after 5 bits
        put_tx(0, 8'h96);
        csn[0] = 1'b0;
        wait_cyc(8);
        xfer(0, 5, 8'hAB, 4, d1);
        check("partial_miso", d1[7:3], 5'b10010);
        wait_cyc(4);
        csn[0] = 1'b1;
        wait_cyc(8);
        check("partial_rx_hold", if0.o_rx_data, 8'hFF);
        check("partial_ready", rdy(0), 1);
        do_word(0, 1'b1, 8'h3A, 8'h55, 4);

        // Asynchronous reset mid-word
        put_tx(0, 8'h5A);
        csn[0] = 1'b0;
        wait_cyc(8);
        put_tx(0, 8'h11);
        xfer(0, 3, 8'hF0, 4, d1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_miso", if0.o_miso, 0);
        check("arst_miso_en", if0.o_miso_en, 0);
        check("arst_ready", if0.o_tx_ready, 1);
        check("arst_rx_data", if0.o_rx_data, 0);
        check("arst_rx_valid", if0.o_rx_valid, 0);
        check("arst_busy", if0.o_busy, 0);
        ph = 2'b00;
        csn = 2'b11;
        mosi_v = 1'b0;
        @(negedge clk);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        do_word(0, 1'b1, 8'h69, 8'hC3, 4);

        // Rate sweep, alternating mode 0 / mode 3
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 100; w++) begin
                do_word(w % 2, 1'b1, 8'($urandom_range(255)),
                        8'($urandom_range(255)), halves[r]);
            end
        end

        wait_cyc(10);
        check("q0_drained", q0.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
